pipelined_datapath: RTL and testbench

//  Parametrised two-stage successor to the single-cycle control-word datapath.
//  - Accepts a stream of control words over a valid/ready handshake and executes each through

---
 rtl/datapath_pkg.sv | 62 ++++++
 rtl/dp_exec_unit.sv | 91 +++++++++
 rtl/pipelined_datapath.sv | 123 ++++++++++++
 tb/tb_pipelined_datapath.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined control-word datapath: control-word layout,
// function/shift opcodes and status-flag bit positions.
package datapath_pkg;

   localparam logic [3:0] FS_A     = 4'h0;
   localparam logic [3:0] FS_INC   = 4'h1;
   localparam logic [3:0] FS_ADD   = 4'h2;
   localparam logic [3:0] FS_ADDC  = 4'h3;
   localparam logic [3:0] FS_ADDNB = 4'h4;
   localparam logic [3:0] FS_SUB   = 4'h5;
   localparam logic [3:0] FS_DEC   = 4'h6;
   localparam logic [3:0] FS_A2    = 4'h7;
   localparam logic [3:0] FS_AND   = 4'h8;
   localparam logic [3:0] FS_OR    = 4'h9;
   localparam logic [3:0] FS_XOR   = 4'hA;
   localparam logic [3:0] FS_NOTA  = 4'hB;
   localparam logic [3:0] FS_B     = 4'hC;

   localparam logic [2:0] SHOP_NONE = 3'd0;
   localparam logic [2:0] SHOP_LSL  = 3'd1;
   localparam logic [2:0] SHOP_LSR  = 3'd2;
   localparam logic [2:0] SHOP_ASR  = 3'd3;
   localparam logic [2:0] SHOP_ROL  = 3'd4;
   localparam logic [2:0] SHOP_ROR  = 3'd5;

   // Bit positions inside the 4-bit {V,C,N,Z} flag vector
   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   function automatic int aw_of(input int nreg);
      return $clog2(nreg);
   endfunction

   function automatic int sw_of(input int dw);
      return $clog2(dw);
   endfunction

   // Control word, MSB->LSB: DA, AA, BA, FS, SHOP, SHAMT, FLW, RW, MB, MD, IMM
   function automatic int cw_width(input int dw, input int nreg);
      return 3 * aw_of(nreg) + 4 + 3 + sw_of(dw) + 4 + dw;
   endfunction

   function automatic int off_md(input int dw);    return dw;                    endfunction
   function automatic int off_mb(input int dw);    return dw + 1;                endfunction
   function automatic int off_rw(input int dw);    return dw + 2;                endfunction
   function automatic int off_flw(input int dw);   return dw + 3;                endfunction
   function automatic int off_shamt(input int dw); return dw + 4;                endfunction
   function automatic int off_shop(input int dw);  return dw + 4 + sw_of(dw);    endfunction
   function automatic int off_fs(input int dw);    return off_shop(dw) + 3;      endfunction
   function automatic int off_ba(input int dw);    return off_fs(dw) + 4;        endfunction

   function automatic int off_aa(input int dw, input int nreg);
      return off_ba(dw) + aw_of(nreg);
   endfunction

   function automatic int off_da(input int dw, input int nreg);
      return off_aa(dw, nreg) + aw_of(nreg);
   endfunction

endpackage

// File: rtl/dp_exec_unit.sv
// Execute-stage arithmetic: barrel shifter on the B operand, function unit and
// {V,C,N,Z} flag generation. Purely combinational.
module dp_exec_unit
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16,
   localparam int SW    = sw_of(DATA_W)
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        fs,
   input  logic [2:0]        shop,
   input  logic [SW-1:0]     shamt,
   output logic [DATA_W-1:0] f,
   output logic [3:0]        flags
);

   function automatic logic add_ovf(input logic sgn_a, input logic sgn_y, input logic sgn_r);
      return (sgn_a == sgn_y) && (sgn_r != sgn_a);
   endfunction

   logic signed [DATA_W-1:0] b_s;
   logic [2*DATA_W-1:0]      rot_l;
   logic [2*DATA_W-1:0]      rot_r;
   logic [DATA_W-1:0]        sb;
   logic [DATA_W-1:0]        opy;
   logic                     cin;
   logic                     arith;
   logic [DATA_W:0]          sum;
   logic                     c_flag;
   logic                     v_flag;

   assign b_s   = b;
   assign rot_l = {b, b} << shamt;
   assign rot_r = {b, b} >> shamt;

   always_comb begin
      sb = b;
      if (shamt != '0) begin
         case (shop)
            SHOP_LSL: sb = b << shamt;
            SHOP_LSR: sb = b >> shamt;
            SHOP_ASR: sb = b_s >>> shamt;
            SHOP_ROL: sb = rot_l[2*DATA_W-1:DATA_W];
            SHOP_ROR: sb = rot_r[DATA_W-1:0];
            default:  sb = b;
         endcase
      end
   end

   // Every code goes through the adder; only FS 1..6 expose carry/overflow
   always_comb begin
      opy   = '0;
      cin   = 1'b0;
      arith = 1'b1;
      case (fs)
         FS_INC:   cin = 1'b1;
         FS_ADD:   opy = sb;
         FS_ADDC:  begin opy = sb;  cin = 1'b1; end
         FS_ADDNB: opy = ~sb;
         FS_SUB:   begin opy = ~sb; cin = 1'b1; end
         FS_DEC:   opy = '1;
         default:  arith = 1'b0;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, opy} + {{DATA_W{1'b0}}, cin};

   always_comb begin
      case (fs)
         FS_AND:                    f = a & sb;
         FS_OR:                     f = a | sb;
         FS_XOR:                    f = a ^ sb;
         FS_NOTA:                   f = ~a;
         FS_B, 4'hD, 4'hE, 4'hF:    f = sb;
         default:                   f = sum[DATA_W-1:0];
      endcase
   end

   assign c_flag = arith & sum[DATA_W];
   assign v_flag = arith & add_ovf(a[DATA_W-1], opy[DATA_W-1], sum[DATA_W-1]);

   always_comb begin
      flags         = '0;
      flags[FLAG_V] = v_flag;
      flags[FLAG_C] = c_flag;
      flags[FLAG_N] = f[DATA_W-1];
      flags[FLAG_Z] = (f == '0);
   end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage control-word datapath: E stage (regfile read, B mux, exec unit, D mux)
// feeding a backpressured W stage that writes back to the register file.
module pipelined_datapath
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   localparam int AW    = aw_of(NREG),
   localparam int SW    = sw_of(DATA_W),
   localparam int CW_W  = cw_width(DATA_W, NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cw_valid,
   output logic              cw_ready,
   input  logic [CW_W-1:0]   cw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        flags,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int DA_LSB    = off_da(DATA_W, NREG);
   localparam int AA_LSB    = off_aa(DATA_W, NREG);
   localparam int BA_LSB    = off_ba(DATA_W);
   localparam int FS_LSB    = off_fs(DATA_W);
   localparam int SHOP_LSB  = off_shop(DATA_W);
   localparam int SHAMT_LSB = off_shamt(DATA_W);

   logic [DATA_W-1:0] rf [NREG];

   logic [AW-1:0]     da_p0, aa_p0, ba_p0;
   logic [3:0]        fs_p0;
   logic [2:0]        shop_p0;
   logic [SW-1:0]     shamt_p0;
   logic              flw_p0, rw_p0, mb_p0, md_p0;
   logic [DATA_W-1:0] imm_p0;
   logic [DATA_W-1:0] a_p0, b_p0, f_p0, d_p0;
   logic [3:0]        flags_p0;

   logic              vld_p1;
   logic [DATA_W-1:0] d_p1;
   logic [AW-1:0]     da_p1;
   logic              rw_p1;
   logic [3:0]        flags_p1;

   logic              adv;
   logic              wb;
   logic              fwd_a, fwd_b;

   assign da_p0    = cw[DA_LSB +: AW];
   assign aa_p0    = cw[AA_LSB +: AW];
   assign ba_p0    = cw[BA_LSB +: AW];
   assign fs_p0    = cw[FS_LSB +: 4];
   assign shop_p0  = cw[SHOP_LSB +: 3];
   assign shamt_p0 = cw[SHAMT_LSB +: SW];
   assign flw_p0   = cw[off_flw(DATA_W)];
   assign rw_p0    = cw[off_rw(DATA_W)];
   assign mb_p0    = cw[off_mb(DATA_W)];
   assign md_p0    = cw[off_md(DATA_W)];
   assign imm_p0   = cw[DATA_W-1:0];

   // ---- E stage: operand fetch with W->E forwarding, execute, D mux ----
   assign fwd_a = vld_p1 && rw_p1 && (da_p1 == aa_p0);
   assign fwd_b = vld_p1 && rw_p1 && (da_p1 == ba_p0);
   assign a_p0  = fwd_a ? d_p1 : rf[aa_p0];
   assign b_p0  = mb_p0 ? imm_p0 : (fwd_b ? d_p1 : rf[ba_p0]);

   dp_exec_unit #(
      .DATA_W (DATA_W)
   ) u_exec (
      .a     (a_p0),
      .b     (b_p0),
      .fs    (fs_p0),
      .shop  (shop_p0),
      .shamt (shamt_p0),
      .f     (f_p0),
      .flags (flags_p0)
   );

   assign d_p0 = md_p0 ? imm_p0 : f_p0;

   // ---- E -> W boundary ----
   assign adv      = !vld_p1 || out_ready;
   assign cw_ready = adv;
   assign wb       = vld_p1 && rw_p1 && out_ready;

   // W data fields only load with a real word, so out_data stays put between words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         d_p1     <= '0;
         da_p1    <= '0;
         rw_p1    <= 1'b0;
         flags_p1 <= '0;
      end else if (adv) begin
         vld_p1 <= cw_valid;
         if (cw_valid) begin
            d_p1  <= d_p0;
            da_p1 <= da_p0;
            rw_p1 <= rw_p0;
            if (flw_p0) flags_p1 <= flags_p0;
         end
      end
   end

   // ---- W stage: writeback when the consumer takes the result ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb) begin
         rf[da_p1] <= d_p1;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = d_p1;
   assign flags     = flags_p1;
   assign dbg_data  = rf[dbg_addr];

endmodule

// File: tb/tb_pipelined_datapath.sv
// Randomised scoreboard bench for pipelined_datapath (DATA_W=16, NREG=8) with
// directed forwarding, overflow, shifter, backpressure, flag-hold and reset scenarios.
module tb_pipelined_datapath;

   localparam int DW   = 16;
   localparam int CW_W = 40;

   typedef struct packed {
      logic [2:0]  da;
      logic [2:0]  aa;
      logic [2:0]  ba;
      logic [3:0]  fs;
      logic [2:0]  shop;
      logic [3:0]  shamt;
      logic        flw;
      logic        rw;
      logic        mb;
      logic        md;
      logic [15:0] imm;
   } tx_t;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  fl;
      logic [2:0]  da;
      logic        rw;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cw_valid = 1'b0;
   logic            cw_ready;
   logic [CW_W-1:0] cw = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [3:0]      flags;
   logic [2:0]      dbg_addr = '0;
   logic [DW-1:0]   dbg_data;

   int n_cmp = 0;
   int n_err = 0;
   int rdy_pct = 100;

   exp_t        q[$];
   logic [15:0] mrf [8] = '{default: '0};
   logic [15:0] crf [8] = '{default: '0};
   logic [3:0]  mflags = '0;

   pipelined_datapath #(.DATA_W(16), .NREG(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cw_valid  (cw_valid),
      .cw_ready  (cw_ready),
      .cw        (cw),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flags     (flags),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic tx_t mk(input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                              input logic [3:0] fs, input logic [2:0] shop, input logic [3:0] shamt,
                              input logic flw, input logic rw, input logic mb, input logic md,
                              input logic [15:0] imm);
      tx_t t;
      t = '{da: da, aa: aa, ba: ba, fs: fs, shop: shop, shamt: shamt,
            flw: flw, rw: rw, mb: mb, md: md, imm: imm};
      return t;
   endfunction

   // Shift applied one bit position at a time
   function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [2:0] op, input logic [3:0] n);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < int'(n); i++) begin
         case (op)
            3'd1:    r = {r[14:0], 1'b0};
            3'd2:    r = {1'b0, r[15:1]};
            3'd3:    r = {r[15], r[15:1]};
            3'd4:    r = {r[14:0], r[15]};
            3'd5:    r = {r[0], r[15:1]};
            default: r = r;
         endcase
      end
      return r;
   endfunction

   // Reference model: integer arithmetic for results, carries and signed overflow
   task automatic model_issue(input tx_t t);
      logic [15:0] a, b, sb, f, d;
      int ua, ub, sa, ssb, us, ss;
      logic c, v, arith;
      exp_t e;
      a   = mrf[t.aa];
      b   = t.mb ? t.imm : mrf[t.ba];
      sb  = m_shift(b, t.shop, t.shamt);
      ua  = int'(a);
      ub  = int'(sb);
      sa  = int'($signed(a));
      ssb = int'($signed(sb));
      us = 0; ss = 0; arith = 1'b1; c = 1'b0; v = 1'b0;
      case (t.fs)
         4'h1: begin us = ua + 1;             ss = sa + 1;           end
         4'h2: begin us = ua + ub;            ss = sa + ssb;         end
         4'h3: begin us = ua + ub + 1;        ss = sa + ssb + 1;     end
         4'h4: begin us = ua + 65535 - ub;    ss = sa - ssb - 1;     end
         4'h5: begin us = ua + 65536 - ub;    ss = sa - ssb;         end
         4'h6: begin us = ua + 65535;         ss = sa - 1;           end
         default: arith = 1'b0;
      endcase
      if (arith) begin
         f = us[15:0];
         c = (us > 65535);
         v = (ss > 32767) || (ss < -32768);
      end else begin
         case (t.fs)
            4'h8:         f = a & sb;
            4'h9:         f = a | sb;
            4'hA:         f = a ^ sb;
            4'hB:         f = ~a;
            4'h0, 4'h7:   f = a;
            default:      f = sb;
         endcase
      end
      d = t.md ? t.imm : f;
      if (t.flw) mflags = {v, c, f[15], (f == 16'h0)};
      if (t.rw) mrf[t.da] = d;
      e.d = d; e.fl = mflags; e.da = t.da; e.rw = t.rw;
      q.push_back(e);
   endtask

   function automatic logic rnd_rdy();
      return ($urandom_range(99) < rdy_pct);
   endfunction

   // Entered and left at 1 time unit after a rising edge
   task automatic cycle(input logic v, input tx_t t, input logic ordy, output bit acc);
      cw_valid  = v;
      cw        = t;
      out_ready = ordy;
      dbg_addr  = 3'($urandom);
      @(negedge clk);
      acc = v && cw_ready;
      if (acc) model_issue(t);
      @(posedge clk);
      #1;
      cw_valid = 1'b0;
   endtask

   task automatic send(input tx_t t);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
         cycle(1'b1, t, rnd_rdy(), acc);
         tries++;
      end
      if (!acc) chk("send_timeout", 32'(tries), 32'(0));
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         cycle(1'b0, '0, 1'b1, acc);
         n++;
      end
      chk("drain_left", 32'(q.size()), 32'(0));
   endtask

   task automatic check_reg(input logic [2:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      chk($sformatf("reg%0d", a), 32'(dbg_data), 32'(exp));
   endtask

   task automatic rand_tx(output tx_t t);
      logic [63:0] r;
      r = {$urandom, $urandom};
      t = r[39:0];
   endtask

   // Monitor: compares W-stage output against the scoreboard and tracks committed state
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 8; i++) crf[i] = '0;
         end else begin
            chk("dbg_data", 32'(dbg_data), 32'(crf[dbg_addr]));
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("spurious_out_valid", 32'(out_valid), 32'(0));
               end else begin
                  chk("out_data", 32'(out_data), 32'(q[0].d));
                  chk("flags", 32'(flags), 32'(q[0].fl));
                  if (out_ready) begin
                     if (q[0].rw) crf[q[0].da] = q[0].d;
                     void'(q.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      tx_t t;

      // Reset state
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_cw_ready", 32'(cw_ready), 32'(1));
      chk("rst_out_data", 32'(out_data), 32'(0));
      chk("rst_flags", 32'(flags), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back dependent words through forwarding
      cycle(1'b1, mk(3'd1, 3'd0, 3'd0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234), 1'b1, acc);
      chk("t1_acc0", 32'(acc), 32'(1));
      chk("t1_out0", 32'(out_data), 32'h1234);
      cycle(1'b1, mk(3'd2, 3'd1, 3'd1, 4'h2, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000), 1'b1, acc);
      chk("t1_acc1", 32'(acc), 32'(1));
      chk("t1_out1", 32'(out_data), 32'h2468);
      drain();
      check_reg(3'd1, 16'h1234);
      check_reg(3'd2, 16'h2468);

      // Signed overflow on add
      send(mk(3'd3, 3'd0, 3'd0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF));
      send(mk(3'd4, 3'd3, 3'd0, 4'h2, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001));
      chk("t2_out", 32'(out_data), 32'h8000);
      chk("t2_flags", 32'(flags), 32'hA);
      drain();
      check_reg(3'd4, 16'h8000);

      // Shifter cases
      send(mk(3'd7, 3'd0, 3'd0, 4'hC, 3'd5, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8001));
      chk("t3_ror", 32'(out_data), 32'hC000);
      send(mk(3'd7, 3'd0, 3'd0, 4'hC, 3'd3, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000));
      chk("t3_asr", 32'(out_data), 32'hF800);
      send(mk(3'd7, 3'd0, 3'd0, 4'hC, 3'd2, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000));
      chk("t3_lsr", 32'(out_data), 32'h0800);
      drain();
      check_reg(3'd7, 16'h0800);

      // Backpressure: two words offered while the consumer stalls
      cycle(1'b1, mk(3'd5, 3'd0, 3'd0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AA), 1'b0, acc);
      chk("t4_acc_first", 32'(acc), 32'(1));
      t = mk(3'd6, 3'd0, 3'd0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0055);
      for (int i = 0; i < 3; i++) begin
         cw_valid  = 1'b1;
         cw        = t;
         out_ready = 1'b0;
         dbg_addr  = 3'd5;
         @(negedge clk);
         chk("t4_cw_ready", 32'(cw_ready), 32'(0));
         chk("t4_out_valid", 32'(out_valid), 32'(1));
         chk("t4_out_stable", 32'(out_data), 32'h00AA);
         chk("t4_rf_held", 32'(dbg_data), 32'h0000);
         @(posedge clk);
         #1;
      end
      cw_valid = 1'b0;
      rdy_pct = 100;
      send(t);
      drain();
      check_reg(3'd5, 16'h00AA);
      check_reg(3'd6, 16'h0055);

      // Zero result sets Z/C; a word with FLW=0 leaves flags alone
      send(mk(3'd5, 3'd0, 3'd0, 4'h0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005));
      send(mk(3'd6, 3'd5, 3'd5, 4'h5, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000));
      chk("t5_out", 32'(out_data), 32'h0000);
      chk("t5_flags", 32'(flags), 32'h5);
      send(mk(3'd7, 3'd0, 3'd0, 4'hC, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001));
      chk("t5_out_noflw", 32'(out_data), 32'h0001);
      chk("t5_flags_hold", 32'(flags), 32'h5);
      drain();

      // Random stream with random backpressure and idle gaps
      rdy_pct = 60;
      for (int i = 0; i < 150; i++) begin
         rand_tx(t);
         if ($urandom_range(3) == 0) cycle(1'b0, '0, rnd_rdy(), acc);
         send(t);
      end
      drain();

      // Reset while a result is waiting in W
      rand_tx(t);
      cycle(1'b1, t, 1'b0, acc);
      chk("t6_acc", 32'(acc), 32'(1));
      chk("t6_pre_valid", 32'(out_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_out_valid", 32'(out_valid), 32'(0));
      chk("t6_flags", 32'(flags), 32'(0));
      chk("t6_out_data", 32'(out_data), 32'(0));
      chk("t6_cw_ready", 32'(cw_ready), 32'(1));
      for (int a = 0; a < 8; a++) begin
         dbg_addr = 3'(a);
         #1;
         chk($sformatf("t6_dbg%0d", a), 32'(dbg_data), 32'(0));
      end
      for (int i = 0; i < 8; i++) mrf[i] = '0;
      mflags = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("t6_post_valid", 32'(out_valid), 32'(0));
      chk("t6_post_ready", 32'(cw_ready), 32'(1));
      chk("t6_post_data", 32'(out_data), 32'(0));

      // Second random stream after reset
      rdy_pct = 70;
      for (int i = 0; i < 300; i++) begin
         rand_tx(t);
         if ($urandom_range(4) == 0) cycle(1'b0, '0, rnd_rdy(), acc);
         send(t);
      end
      drain();
      for (int a = 0; a < 8; a++) check_reg(3'(a), mrf[a]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
